// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter sprite path.
//   anim_state_e  : animation state encodings S_IDLE..S_HIT
//   NFRM_*        : frames per animation state
//   BASE_*        : sprite ROM base address per state (frame-major, contiguous)
//   FRAME_STRIDE  : words per sprite frame (32 x 48)
//   nfrm_of/base_of : table lookups; out-of-range states map to IDLE
package fighter_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WALK = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5
    } anim_state_e;

    localparam int unsigned FRAME_STRIDE = 32 * 48;

    localparam int unsigned NFRM_IDLE = 1;
    localparam int unsigned NFRM_WALK = 4;
    localparam int unsigned NFRM_JUMP = 8;
    localparam int unsigned NFRM_ATK1 = 6;
    localparam int unsigned NFRM_ATK2 = 8;
    localparam int unsigned NFRM_HIT  = 1;

    // Each state's frames follow directly after the previous state's.
    localparam int unsigned BASE_IDLE = 0;
    localparam int unsigned BASE_WALK = BASE_IDLE + NFRM_IDLE * FRAME_STRIDE;
    localparam int unsigned BASE_JUMP = BASE_WALK + NFRM_WALK * FRAME_STRIDE;
    localparam int unsigned BASE_ATK1 = BASE_JUMP + NFRM_JUMP * FRAME_STRIDE;
    localparam int unsigned BASE_ATK2 = BASE_ATK1 + NFRM_ATK1 * FRAME_STRIDE;
    localparam int unsigned BASE_HIT  = BASE_ATK2 + NFRM_ATK2 * FRAME_STRIDE;

    function automatic logic [3:0] nfrm_of(input logic [3:0] st);
        case (st)
            S_WALK:  return 4'(NFRM_WALK);
            S_JUMP:  return 4'(NFRM_JUMP);
            S_ATK1:  return 4'(NFRM_ATK1);
            S_ATK2:  return 4'(NFRM_ATK2);
            S_HIT:   return 4'(NFRM_HIT);
            default: return 4'(NFRM_IDLE);
        endcase
    endfunction

    function automatic logic [31:0] base_of(input logic [3:0] st);
        case (st)
            S_WALK:  return 32'(BASE_WALK);
            S_JUMP:  return 32'(BASE_JUMP);
            S_ATK1:  return 32'(BASE_ATK1);
            S_ATK2:  return 32'(BASE_ATK2);
            S_HIT:   return 32'(BASE_HIT);
            default: return 32'(BASE_IDLE);
        endcase
    endfunction

endpackage

// File: rtl/sprite_frame_lut.sv
// Combinational animation lookup: state + anim_frame -> ROM base and frame index.
//   anim_state : animation state (values > 5 behave as IDLE)
//   anim_frame : tick counter within the state
//   base       : ROM base address of the state's first frame
//   idx        : sprite frame index, clamped to the state's last frame
module sprite_frame_lut
    import fighter_pkg::*;
#(
    parameter int unsigned FRM_SHFT = 2
) (
    input  logic [3:0]  anim_state,
    input  logic [5:0]  anim_frame,
    output logic [31:0] base,
    output logic [2:0]  idx
);

    logic [5:0] raw_idx;
    logic [3:0] nfrm;

    always_comb begin
        raw_idx = anim_frame >> FRM_SHFT;
        nfrm    = nfrm_of(anim_state);
        base    = base_of(anim_state);
        if (raw_idx >= {2'b00, nfrm}) begin
            idx = 3'(nfrm - 4'd1);
        end else begin
            idx = raw_idx[2:0];
        end
    end

endmodule

// File: rtl/player_sprite_fetch.sv
// Per-player sprite fetch: turns pixel queries into sprite-ROM reads and
// answers each query with colour + opaque flag after a fixed ROM_LAT+2 cycles.
//   clk, reset_n          : clock, async active-low reset
//   frame_start           : latches anim/facing/position into shadow registers
//   anim_state/anim_frame : animation selection
//   facing_left           : horizontal mirror
//   pos_x, pos_y          : sprite top-left on screen
//   pix_valid/x/y         : pixel query stream
//   rom_addr / rom_data   : sprite ROM port (data ROM_LAT cycles after addr)
//   out_valid/opaque/color: in-order query responses
module player_sprite_fetch
    import fighter_pkg::*;
#(
    parameter int unsigned        SPR_W    = 32,
    parameter int unsigned        SPR_H    = 48,
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        COLOR_W  = 12,
    parameter int unsigned        ROM_LAT  = 1,
    parameter logic [COLOR_W-1:0] TRANSP   = 12'hF0F,
    parameter int unsigned        FRM_SHFT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic [3:0]         anim_state,
    input  logic [5:0]         anim_frame,
    input  logic               facing_left,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               pix_valid,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               out_valid,
    output logic               out_opaque,
    output logic [COLOR_W-1:0] out_color
);

    localparam int unsigned STRIDE = SPR_W * SPR_H;

    logic [3:0] sh_state;
    logic [5:0] sh_frame;
    logic       sh_left;
    logic [9:0] sh_x;
    logic [9:0] sh_y;

    logic [31:0]       lut_base;
    logic [2:0]        lut_idx;
    logic              hit;
    logic [9:0]        col_raw;
    logic [9:0]        col;
    logic [9:0]        row;
    logic [ADDR_W-1:0] addr_next;

    // Stage k of the delay line is the query k+1 cycles after acceptance.
    logic [ROM_LAT:0] vld_pipe;
    logic [ROM_LAT:0] hit_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_state <= S_IDLE;
            sh_frame <= '0;
            sh_left  <= 1'b0;
            sh_x     <= '0;
            sh_y     <= '0;
        end else if (frame_start) begin
            sh_state <= anim_state;
            sh_frame <= anim_frame;
            sh_left  <= facing_left;
            sh_x     <= pos_x;
            sh_y     <= pos_y;
        end
    end

    sprite_frame_lut #(
        .FRM_SHFT (FRM_SHFT)
    ) u_lut (
        .anim_state (sh_state),
        .anim_frame (sh_frame),
        .base       (lut_base),
        .idx        (lut_idx)
    );

    // 11-bit compares so a sprite near the right/bottom edge cannot wrap.
    always_comb begin
        hit = ({1'b0, pix_x} >= {1'b0, sh_x}) &&
              ({1'b0, pix_x} <  ({1'b0, sh_x} + 11'(SPR_W))) &&
              ({1'b0, pix_y} >= {1'b0, sh_y}) &&
              ({1'b0, pix_y} <  ({1'b0, sh_y} + 11'(SPR_H)));
        col_raw   = pix_x - sh_x;
        col       = sh_left ? (10'(SPR_W - 1) - col_raw) : col_raw;
        row       = pix_y - sh_y;
        addr_next = ADDR_W'(lut_base + 32'(lut_idx) * STRIDE
                            + 32'(row) * SPR_W + 32'(col));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            vld_pipe <= '0;
            hit_pipe <= '0;
        end else begin
            if (pix_valid && hit) begin
                rom_addr <= addr_next;
            end
            vld_pipe <= {vld_pipe[ROM_LAT-1:0], pix_valid};
            hit_pipe <= {hit_pipe[ROM_LAT-1:0], pix_valid && hit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_opaque <= 1'b0;
            out_color  <= '0;
        end else begin
            out_valid <= vld_pipe[ROM_LAT];
            if (hit_pipe[ROM_LAT] && (rom_data != TRANSP)) begin
                out_opaque <= 1'b1;
                out_color  <= rom_data;
            end else begin
                out_opaque <= 1'b0;
                out_color  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Scoreboard bench for player_sprite_fetch (ROM_LAT=1, latency 3).
module tb_player_sprite_fetch;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  anim_state = '0;
    logic [5:0]  anim_frame = '0;
    logic        facing_left = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [15:0] rom_addr;
    logic [11:0] rom_data;
    logic        out_valid;
    logic        out_opaque;
    logic [11:0] out_color;

    player_sprite_fetch #(
        .SPR_W    (32),
        .SPR_H    (48),
        .ADDR_W   (16),
        .COLOR_W  (12),
        .ROM_LAT  (1),
        .TRANSP   (12'hF0F),
        .FRM_SHFT (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .anim_state  (anim_state),
        .anim_frame  (anim_frame),
        .facing_left (facing_left),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_opaque  (out_opaque),
        .out_color   (out_color)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: one-cycle registered read; force_transp makes every word the key.
    logic force_transp = 1'b0;
    function automatic logic [11:0] rom_fn(input logic [15:0] a);
        return a[11:0] ^ 12'hA53;
    endfunction
    always @(posedge clk) rom_data <= force_transp ? 12'hF0F : rom_fn(rom_addr);

    // Reference shadow state and tables.
    int m_state = 0, m_frame = 0, m_left = 0, m_x = 0, m_y = 0;
    int nfrm_t [6] = '{1, 4, 8, 6, 8, 1};
    int base_t [6] = '{0, 1536, 7680, 19968, 29184, 41472};

    function automatic bit exp_hit(input int px, input int py);
        return (px >= m_x) && (px < m_x + 32) && (py >= m_y) && (py < m_y + 48);
    endfunction

    function automatic int exp_addr(input int px, input int py);
        int st, idx, col, row;
        st  = (m_state > 5) ? 0 : m_state;
        idx = m_frame >> 2;
        if (idx > nfrm_t[st] - 1) idx = nfrm_t[st] - 1;
        col = px - m_x;
        if (m_left != 0) col = 31 - col;
        row = py - m_y;
        return (base_t[st] + idx * 1536 + row * 32 + col) % 65536;
    endfunction

    typedef struct {
        bit          op;
        logic [11:0] col;
        int          cyc;
    } resp_t;
    resp_t sb[$];
    resp_t mon_r;

    // Response monitor: each out_valid pops one expectation; bubbles must be zero.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp cyc=%0d opaque=%0b color=%0h", cyc, out_opaque, out_color);
                end else begin
                    mon_r = sb.pop_front();
                    if (out_opaque !== mon_r.op || out_color !== mon_r.col || cyc !== mon_r.cyc) begin
                        failures++;
                        $display("FAIL resp got op=%0b col=%0h cyc=%0d exp op=%0b col=%0h cyc=%0d",
                                 out_opaque, out_color, cyc, mon_r.op, mon_r.col, mon_r.cyc);
                    end
                end
            end else begin
                checks++;
                if (out_opaque !== 1'b0 || out_color !== 12'h000) begin
                    failures++;
                    $display("FAIL bubble got op=%0b col=%0h exp op=0 col=0", out_opaque, out_color);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_frame_start(input int st, input int fr, input int lf, input int x, input int y);
        anim_state  = 4'(st);
        anim_frame  = 6'(fr);
        facing_left = lf[0];
        pos_x       = 10'(x);
        pos_y       = 10'(y);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        m_state = st; m_frame = fr; m_left = lf; m_x = x; m_y = y;
    endtask

    task automatic push_exp(input int px, input int py);
        resp_t r;
        bit    h;
        int    a;
        h = exp_hit(px, py);
        a = exp_addr(px, py);
        r.op  = h && !force_transp && (rom_fn(16'(a)) != 12'hF0F);
        r.col = r.op ? rom_fn(16'(a)) : 12'h000;
        r.cyc = cyc + L;
        sb.push_back(r);
    endtask

    task automatic drive_query(input int px, input int py);
        pix_x = 10'(px);
        pix_y = 10'(py);
        pix_valid = 1'b1;
        push_exp(px, py);
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rom_addr !== 16'h0000 || out_valid !== 1'b0 || out_opaque !== 1'b0 || out_color !== 12'h000) begin
            failures++;
            $display("FAIL reset_state addr=%0h v=%0b op=%0b col=%0h required all 0",
                     rom_addr, out_valid, out_opaque, out_color);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        // Shadow comes out of reset as IDLE at (0,0), facing right.
        drive_query(3, 1);
        checks++;
        if (rom_addr !== 16'd35) begin
            failures++;
            $display("FAIL reset_shadow_addr got=%0d required=35", rom_addr);
        end
        drain();
    endtask

    task automatic test_basic();
        do_frame_start(0, 0, 0, 100, 50);
        drive_query(100, 50);
        checks++;
        if (rom_addr !== 16'd0) begin
            failures++;
            $display("FAIL basic_addr got=%0d required=0", rom_addr);
        end
        drive_query(103, 51);
        checks++;
        if (rom_addr !== 16'd35) begin
            failures++;
            $display("FAIL basic_addr2 got=%0d required=35", rom_addr);
        end
        drain();
    endtask

    task automatic test_frame_select();
        do_frame_start(1, 13, 0, 100, 50);
        drive_query(105, 52);
        checks++;
        if (rom_addr !== 16'd6213) begin
            failures++;
            $display("FAIL walk_right_addr got=%0d required=6213", rom_addr);
        end
        do_frame_start(1, 13, 1, 100, 50);
        drive_query(105, 52);
        checks++;
        if (rom_addr !== 16'd6234) begin
            failures++;
            $display("FAIL walk_left_addr got=%0d required=6234", rom_addr);
        end
        do_frame_start(4, 63, 0, 100, 50);
        drive_query(100, 50);
        checks++;
        if (rom_addr !== 16'd39936) begin
            failures++;
            $display("FAIL atk2_clamp_addr got=%0d required=39936", rom_addr);
        end
        do_frame_start(9, 40, 0, 100, 50);
        drive_query(101, 50);
        checks++;
        if (rom_addr !== 16'd1) begin
            failures++;
            $display("FAIL bad_state_addr got=%0d required=1", rom_addr);
        end
        drain();
    endtask

    task automatic test_edges();
        do_frame_start(1, 0, 0, 100, 50);
        drive_query(131, 97);
        checks++;
        if (rom_addr !== 16'd3071) begin
            failures++;
            $display("FAIL corner_addr got=%0d required=3071", rom_addr);
        end
        drive_query(132, 50);
        drive_query(99, 50);
        drive_query(100, 98);
        drive_query(100, 49);
        checks++;
        if (rom_addr !== 16'd3071) begin
            failures++;
            $display("FAIL miss_hold_addr got=%0d required=3071", rom_addr);
        end
        drain();
        force_transp = 1'b1;
        drive_query(110, 60);
        drain();
        force_transp = 1'b0;
    endtask

    task automatic test_no_tearing();
        do_frame_start(2, 20, 0, 200, 100);
        anim_state = 4'd5;
        anim_frame = 6'd0;
        pos_x = 10'd0;
        pos_y = 10'd0;
        facing_left = 1'b1;
        drive_query(210, 110);
        checks++;
        if (rom_addr !== 16'd15690) begin
            failures++;
            $display("FAIL tearing_addr got=%0d required=15690", rom_addr);
        end
        // frame_start and query together: query still sees the old shadow.
        anim_state = 4'd3; anim_frame = 6'd8; facing_left = 1'b1;
        pos_x = 10'd300; pos_y = 10'd200;
        frame_start = 1'b1;
        pix_x = 10'd210; pix_y = 10'd110; pix_valid = 1'b1;
        push_exp(210, 110);
        @(posedge clk); #1;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        m_state = 3; m_frame = 8; m_left = 1; m_x = 300; m_y = 200;
        checks++;
        if (rom_addr !== 16'd15690) begin
            failures++;
            $display("FAIL coincident_addr got=%0d required=15690", rom_addr);
        end
        drive_query(300, 200);
        checks++;
        if (rom_addr !== 16'd23071) begin
            failures++;
            $display("FAIL after_fs_addr got=%0d required=23071", rom_addr);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        do_frame_start(1, 7, 0, 100, 50);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                drive_query(int'($urandom_range(96, 135)), int'($urandom_range(46, 100)));
            end else begin
                @(posedge clk); #1;
            end
        end
        do_frame_start(3, 17, 1, 100, 50);
        for (int i = 0; i < 16; i++) drive_query(100 + i, 50 + i);
        drain();
    endtask

    task automatic test_reset_midstream();
        do_frame_start(2, 4, 0, 100, 50);
        drive_query(101, 51);
        drive_query(102, 52);
        drive_query(103, 53);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_valid got=%0b required=0", out_valid);
        end
        sb.delete();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        m_state = 0; m_frame = 0; m_left = 0; m_x = 0; m_y = 0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 16'd0) begin
            failures++;
            $display("FAIL post_reset_idle v=%0b addr=%0d required v=0 addr=0", out_valid, rom_addr);
        end
        drive_query(5, 5);
        checks++;
        if (rom_addr !== 16'd165) begin
            failures++;
            $display("FAIL post_reset_addr got=%0d required=165", rom_addr);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_frame_select();
        test_edges();
        test_no_tearing();
        test_back_to_back();
        test_reset_midstream();
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
